// File: rtl/aes_keyslot_pkg.sv
// Shared definitions for the AES key-slot controller: FSM states, register word map,
// CTRL/STATUS bit positions and lock-bit positions.
package aes_keyslot_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_BUSY = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Word indices (address_i[8:3]); each PT/IV/CT/KEY word carries 32 bits, word 0 is bits [31:0].
    localparam logic [5:0] W_CTRL   = 6'd0;
    localparam logic [5:0] W_STATUS = 6'd1;
    localparam logic [5:0] W_PT     = 6'd2;
    localparam logic [5:0] W_IV     = 6'd6;
    localparam logic [5:0] W_CT     = 6'd10;
    localparam logic [5:0] W_CT_END = 6'd14;
    localparam logic [5:0] W_KEY    = 6'd16;

    localparam int CTRL_START   = 0;
    localparam int CTRL_ZEROIZE = 1;
    localparam int CTRL_KSEL    = 2;
    localparam int CTRL_ERR_CLR = 5;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;
    localparam int STAT_KSEL = 3;

    localparam int LK_CTRL_WR   = 1;
    localparam int LK_PTIV_RD   = 2;
    localparam int LK_PTIV_WR   = 3;
    localparam int LK_CT_RD     = 4;
    localparam int LK_KEY_WR    = 5;
    localparam int LK_STATUS_RD = 6;

    function automatic logic [31:0] word_of(input logic [127:0] v, input logic [1:0] w);
        case (w)
            2'd0:    return v[31:0];
            2'd1:    return v[63:32];
            2'd2:    return v[95:64];
            default: return v[127:96];
        endcase
    endfunction

endpackage

// File: rtl/aes_keyslot_bank.sv
// Write-only key storage: per-word writes, single-cycle zeroize of every slot, and the
// selection mux feeding the core snapshot (out-of-range selections yield zero).
module aes_keyslot_bank
    import aes_keyslot_pkg::*;
#(
    parameter int NUM_KEYS = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [2:0]   wr_slot,
    input  logic [1:0]   wr_word,
    input  logic [31:0]  wr_data,
    input  logic         zeroize,
    input  logic [2:0]   sel,
    output logic [127:0] sel_key
);

    logic [127:0] keys [NUM_KEYS];

    // Zeroize shares the reset path so it always wins over a same-cycle key write.
    always_ff @(posedge clk) begin
        if (!rst_n || zeroize) begin
            for (int s = 0; s < NUM_KEYS; s++) keys[s] <= '0;
        end else if (wr_en) begin
            for (int s = 0; s < NUM_KEYS; s++) begin
                for (int w = 0; w < 4; w++) begin
                    if (wr_slot == 3'(s) && wr_word == 2'(w)) keys[s][32*w +: 32] <= wr_data;
                end
            end
        end
    end

    always_comb begin
        sel_key = '0;
        for (int s = 0; s < NUM_KEYS; s++) begin
            if (sel == 3'(s)) sel_key = keys[s];
        end
    end

endmodule

// File: rtl/aes_keyslot_ctrl.sv
// Register-bus front end and sequencing FSM for an external AES core with selectable key slots.
// Handshake: core_start_o is a one-cycle pulse; the core answers with a one-cycle core_valid_i.
module aes_keyslot_ctrl
    import aes_keyslot_pkg::*;
#(
    parameter int NUM_KEYS    = 4,
    parameter int TIMEOUT_CYC = 1024,
    parameter int ADDR_W      = 64
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] address_i,
    input  logic [63:0]       wdata_i,
    output logic [63:0]       rdata_o,
    input  logic [7:0]        reglk_ctrl_i,
    output logic              core_start_o,
    output logic [127:0]      core_key_o,
    output logic [127:0]      core_pt_o,
    output logic [127:0]      core_iv_o,
    input  logic [127:0]      core_ct_i,
    input  logic              core_valid_i,
    output logic [1:0]        dbg_state
);

    localparam logic [3:0]  NK      = 4'(NUM_KEYS);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

    state_t        state, state_d;
    logic [15:0]   cnt;
    logic [127:0]  pt, iv, ct, bank_key;
    logic [2:0]    key_sel, wsel;
    logic          err, err_set, ct_capture, ct_clear;
    logic [5:0]    idx, key_off;
    logic [1:0]    pt_w, iv_w, ct_w;
    logic          pt_hit, iv_hit, ct_hit, key_hit, active;
    logic          wr, ctrl_wr, start_req, zeroize, err_clr, ptiv_wr, key_wr;
    logic          unused_bits;

    assign idx     = address_i[8:3];
    assign key_off = idx - W_KEY;
    assign pt_w    = 2'(idx - W_PT);
    assign iv_w    = 2'(idx - W_IV);
    assign ct_w    = 2'(idx - W_CT);
    assign pt_hit  = (idx >= W_PT) && (idx < W_IV);
    assign iv_hit  = (idx >= W_IV) && (idx < W_CT);
    assign ct_hit  = (idx >= W_CT) && (idx < W_CT_END);
    assign key_hit = (idx >= W_KEY) && (key_off[5:2] < NK);
    assign active  = (state == ST_LOAD) || (state == ST_BUSY);

    assign wr        = en_i && we_i;
    assign ctrl_wr   = wr && (idx == W_CTRL) && !reglk_ctrl_i[LK_CTRL_WR];
    assign start_req = ctrl_wr && wdata_i[CTRL_START];
    assign zeroize   = ctrl_wr && wdata_i[CTRL_ZEROIZE];
    assign err_clr   = ctrl_wr && wdata_i[CTRL_ERR_CLR];
    assign wsel      = wdata_i[CTRL_KSEL +: 3];
    // PT/IV/KEY are frozen while an operation is in flight so snapshots stay coherent.
    assign ptiv_wr   = wr && !active && !reglk_ctrl_i[LK_PTIV_WR];
    assign key_wr    = wr && key_hit && !active && !reglk_ctrl_i[LK_KEY_WR];

    assign dbg_state   = state;
    assign unused_bits = ^{address_i[ADDR_W-1:9], address_i[2:0], wdata_i[63:32],
                           reglk_ctrl_i[7], reglk_ctrl_i[0]};

    aes_keyslot_bank #(.NUM_KEYS(NUM_KEYS)) u_bank (
        .clk     (clk_i),
        .rst_n   (rst_ni),
        .wr_en   (key_wr),
        .wr_slot (key_off[4:2]),
        .wr_word (key_off[1:0]),
        .wr_data (wdata_i[31:0]),
        .zeroize (zeroize),
        .sel     (key_sel),
        .sel_key (bank_key)
    );

    always_comb begin
        state_d    = state;
        err_set    = 1'b0;
        ct_capture = 1'b0;
        ct_clear   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start_req) begin
                    if ({1'b0, wsel} >= NK) err_set = 1'b1;
                    else if (!err)          state_d = ST_LOAD;
                end
            end
            ST_LOAD: state_d = ST_BUSY;
            ST_BUSY: begin
                if (zeroize) begin
                    state_d  = ST_IDLE;
                    err_set  = 1'b1;
                    ct_clear = 1'b1;
                end else if (core_valid_i) begin
                    state_d    = ST_DONE;
                    ct_capture = 1'b1;
                end else if (cnt == TO_LAST) begin
                    state_d = ST_IDLE;
                    err_set = 1'b1;
                end
            end
            ST_DONE: if (ctrl_wr) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            err          <= 1'b0;
            key_sel      <= '0;
            pt           <= '0;
            iv           <= '0;
            ct           <= '0;
            core_start_o <= 1'b0;
            core_key_o   <= '0;
            core_pt_o    <= '0;
            core_iv_o    <= '0;
        end else begin
            state        <= state_d;
            cnt          <= (state == ST_BUSY && state_d == ST_BUSY) ? cnt + 16'd1 : '0;
            core_start_o <= (state == ST_LOAD);
            if (err_set)      err <= 1'b1;
            else if (err_clr) err <= 1'b0;
            if (ctrl_wr && !active) key_sel <= wsel;
            for (int w = 0; w < 4; w++) begin
                if (ptiv_wr && pt_hit && pt_w == 2'(w)) pt[32*w +: 32] <= wdata_i[31:0];
                if (ptiv_wr && iv_hit && iv_w == 2'(w)) iv[32*w +: 32] <= wdata_i[31:0];
            end
            if (ct_clear)        ct <= '0;
            else if (ct_capture) ct <= core_ct_i;
            if (state == ST_LOAD) begin
                core_key_o <= bank_key;
                core_pt_o  <= pt;
                core_iv_o  <= iv;
            end
            // Never leave key material on the core port once the slots are wiped.
            if (zeroize) core_key_o <= '0;
        end
    end

    always_comb begin
        rdata_o = '0;
        if (en_i && !we_i) begin
            if (idx == W_CTRL) begin
                rdata_o[CTRL_KSEL +: 3] = key_sel;
            end else if (idx == W_STATUS) begin
                if (!reglk_ctrl_i[LK_STATUS_RD]) begin
                    rdata_o[STAT_BUSY]     = active;
                    rdata_o[STAT_DONE]     = (state == ST_DONE);
                    rdata_o[STAT_ERR]      = err;
                    rdata_o[STAT_KSEL +: 3] = key_sel;
                end
            end else if (pt_hit) begin
                if (!reglk_ctrl_i[LK_PTIV_RD]) rdata_o[31:0] = word_of(pt, pt_w);
            end else if (iv_hit) begin
                if (!reglk_ctrl_i[LK_PTIV_RD]) rdata_o[31:0] = word_of(iv, iv_w);
            end else if (ct_hit) begin
                if (!reglk_ctrl_i[LK_CT_RD]) rdata_o[31:0] = word_of(ct, ct_w);
            end
        end
    end

endmodule

// File: tb/tb_aes_keyslot_ctrl.sv
// Bench for aes_keyslot_ctrl: directed scenarios plus randomized key/PT/IV/op traffic,
// checked against a transaction-level model of the key slots, data registers and err flag.
module tb_aes_keyslot_ctrl;
    import aes_keyslot_pkg::*;

    localparam int NK = 2;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         we = 1'b0;
    logic [63:0]  addr = '0;
    logic [63:0]  wdata = '0;
    logic [63:0]  rdata;
    logic [7:0]   reglk = '0;
    logic         core_start;
    logic [127:0] core_key, core_pt, core_iv;
    logic [127:0] core_ct = '0;
    logic         core_valid = 1'b0;
    logic [1:0]   dbg_state;

    int tests = 0;
    int fails = 0;
    int pulses = 0;

    logic [127:0] keys_m [NK];
    logic [127:0] pt_m, iv_m, ct_m;
    logic         err_m;
    logic [2:0]   ksel_m;

    aes_keyslot_ctrl #(.NUM_KEYS(NK), .TIMEOUT_CYC(TO), .ADDR_W(64)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .en_i         (en),
        .we_i         (we),
        .address_i    (addr),
        .wdata_i      (wdata),
        .rdata_o      (rdata),
        .reglk_ctrl_i (reglk),
        .core_start_o (core_start),
        .core_key_o   (core_key),
        .core_pt_o    (core_pt),
        .core_iv_o    (core_iv),
        .core_ct_i    (core_ct),
        .core_valid_i (core_valid),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (core_start) pulses++;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input int idx, input logic [63:0] d);
        en = 1'b1; we = 1'b1; addr = 64'(idx) << 3; wdata = d;
        @(posedge clk); #1;
        en = 1'b0; we = 1'b0;
    endtask

    task automatic bus_rd(input int idx, output logic [63:0] d);
        en = 1'b1; we = 1'b0; addr = 64'(idx) << 3;
        #1 d = rdata;
        en = 1'b0;
        @(posedge clk); #1;
    endtask

    function automatic logic [63:0] st(input logic busy, input logic done, input logic err,
                                       input logic [2:0] ks);
        return {58'd0, ks, err, done, busy};
    endfunction

    task automatic key_wr(input int slot, input int w, input logic [31:0] d);
        bus_wr(16 + 4 * slot + w, {32'd0, d});
        if (!reglk[5]) keys_m[slot][32*w +: 32] = d;
    endtask

    task automatic pt_wr(input int w, input logic [31:0] d);
        bus_wr(2 + w, {32'd0, d});
        if (!reglk[3]) pt_m[32*w +: 32] = d;
    endtask

    task automatic iv_wr(input int w, input logic [31:0] d);
        bus_wr(6 + w, {32'd0, d});
        if (!reglk[3]) iv_m[32*w +: 32] = d;
    endtask

    task automatic check_ct(input string tag);
        logic [63:0] r;
        for (int w = 0; w < 4; w++) begin
            bus_rd(10 + w, r);
            check(tag, r, {32'd0, ct_m[32*w +: 32]});
        end
    endtask

    // Full operation with a legal key_sel; lat = extra idle cycles before core_valid_i.
    task automatic run_op(input logic [2:0] ks, input int lat);
        int p0;
        logic [63:0] r;
        logic [127:0] ct;
        p0 = pulses;
        bus_wr(0, (64'(ks) << 2) | 64'd1);
        ksel_m = ks;
        check("op_no_early_start", core_start, 0);
        cyc(1);
        check("op_start_pulse", core_start, 1);
        check("op_core_key", core_key, keys_m[int'(ks)]);
        check("op_core_pt", core_pt, pt_m);
        check("op_core_iv", core_iv, iv_m);
        cyc(1);
        check("op_start_one_cycle", core_start, 0);
        ct = {$urandom, $urandom, $urandom, $urandom};
        cyc(lat);
        core_valid = 1'b1; core_ct = ct;
        cyc(1);
        core_valid = 1'b0; core_ct = ~ct;
        ct_m = ct;
        bus_rd(1, r);
        check("op_status_done", r, st(1'b0, 1'b1, err_m, ks));
        check_ct("op_ct_word");
        check("op_pulse_count", 128'(pulses - p0), 1);
        bus_wr(0, 64'(ks) << 2);
        bus_rd(1, r);
        check("op_status_idle", r, st(1'b0, 1'b0, err_m, ks));
    endtask

    // Start with key_sel out of range: err set, no pulse; then clear err.
    task automatic bad_start(input logic [2:0] ks);
        int p0;
        logic [63:0] r;
        p0 = pulses;
        bus_wr(0, (64'(ks) << 2) | 64'd1);
        ksel_m = ks; err_m = 1'b1;
        cyc(3);
        check("bad_no_pulse", 128'(pulses - p0), 0);
        bus_rd(1, r);
        check("bad_status_err", r, st(1'b0, 1'b0, 1'b1, ks));
        bus_wr(0, 64'h20 | (64'(ks) << 2));
        err_m = 1'b0;
        bus_rd(1, r);
        check("bad_err_cleared", r, st(1'b0, 1'b0, 1'b0, ks));
    endtask

    initial begin
        logic [63:0]  r;
        logic [127:0] k;
        int p0;

        for (int s = 0; s < NK; s++) keys_m[s] = '0;
        pt_m = '0; iv_m = '0; ct_m = '0; err_m = 1'b0; ksel_m = '0;

        // Reset state
        rst_n = 1'b0;
        cyc(3);
        check("rst_core_start", core_start, 0);
        check("rst_core_key", core_key, 0);
        check("rst_core_pt", core_pt, 0);
        check("rst_core_iv", core_iv, 0);
        check("rst_state_idle", dbg_state, ST_IDLE);
        rst_n = 1'b1;
        cyc(1);
        bus_rd(1, r);
        check("rst_status", r, 0);

        // Known-key operation on slot 1
        k = 128'h000102030405060708090a0b0c0d0e0f;
        for (int w = 0; w < 4; w++) key_wr(1, w, k[32*w +: 32]);
        for (int w = 0; w < 4; w++) pt_wr(w, $urandom);
        for (int w = 0; w < 4; w++) iv_wr(w, $urandom);
        run_op(3'd1, 8);
        check("known_key_value", core_key, k);
        bus_rd(0, r);
        check("ctrl_readback", r, 64'h4);
        en = 1'b0; we = 1'b0; addr = 64'(1) << 3;
        #1 check("rdata_zero_en_low", rdata, 0);
        cyc(1);

        // Key words always read zero; unmapped indices read zero
        for (int i = 16; i < 16 + 4 * NK; i++) begin
            bus_rd(i, r);
            check("key_read_zero", r, 0);
        end
        bus_rd(14, r); check("unmapped_14", r, 0);
        bus_rd(63, r); check("unmapped_63", r, 0);
        for (int w = 0; w < 4; w++) begin
            bus_rd(2 + w, r); check("pt_readback", r, {32'd0, pt_m[32*w +: 32]});
            bus_rd(6 + w, r); check("iv_readback", r, {32'd0, iv_m[32*w +: 32]});
        end

        // Lock bits
        reglk = 8'h04; bus_rd(2, r); check("lock_ptiv_rd", r, 0);
        reglk = 8'h08; pt_wr(0, $urandom);
        reglk = 8'h00; bus_rd(2, r); check("lock_ptiv_wr", r, {32'd0, pt_m[31:0]});
        reglk = 8'h40; bus_rd(1, r); check("lock_status_rd", r, 0);
        reglk = 8'h10; bus_rd(10, r); check("lock_ct_rd", r, 0);
        reglk = 8'h00; bus_rd(10, r); check("ct_unlocked", r, {32'd0, ct_m[31:0]});
        reglk = 8'h02; bus_wr(0, 64'h1);
        reglk = 8'h00; cyc(2);
        bus_rd(1, r); check("lock_ctrl_wr", r, st(1'b0, 1'b0, 1'b0, ksel_m));

        // Locked key write leaves slot 0 at zero
        reglk = 8'h20; key_wr(0, 0, 32'hDEADBEEF);
        reglk = 8'h00;
        run_op(3'd0, 3);
        check("locked_key_zero", core_key, 0);

        // Writes during LOAD/BUSY are ignored
        p0 = pulses;
        bus_wr(0, 64'h5);
        ksel_m = 3'd1;
        bus_wr(2, {32'd0, ~pt_m[31:0]});
        check("busy_snapshot_pt", core_pt, pt_m);
        check("busy_snapshot_key", core_key, keys_m[1]);
        bus_wr(20, 64'h12345678);
        bus_wr(0, 64'h1);
        core_valid = 1'b1; core_ct = {$urandom, $urandom, $urandom, $urandom};
        ct_m = core_ct;
        cyc(1);
        core_valid = 1'b0;
        bus_rd(1, r); check("busy_ignored_status", r, st(1'b0, 1'b1, 1'b0, 3'd1));
        check("busy_ignored_pulses", 128'(pulses - p0), 1);
        bus_wr(0, 64'h4);
        bus_rd(2, r); check("busy_pt_unchanged", r, {32'd0, pt_m[31:0]});
        run_op(3'd1, 2);

        // Randomized traffic
        for (int it = 0; it < 8; it++) begin
            key_wr($urandom_range(0, NK - 1), $urandom_range(0, 3), $urandom);
            pt_wr($urandom_range(0, 3), $urandom);
            iv_wr($urandom_range(0, 3), $urandom);
            k[2:0] = 3'($urandom_range(0, 3));
            if (int'(k[2:0]) < NK) run_op(k[2:0], $urandom_range(0, 12));
            else bad_start(k[2:0]);
        end

        // Timeout
        bus_wr(0, 64'h1);
        ksel_m = 3'd0;
        cyc(1);
        cyc(TO - 1);
        bus_rd(1, r); check("timeout_still_busy", r, st(1'b1, 1'b0, 1'b0, 3'd0));
        err_m = 1'b1;
        bus_rd(1, r); check("timeout_err_idle", r, st(1'b0, 1'b0, 1'b1, 3'd0));
        p0 = pulses;
        bus_wr(0, 64'h1);
        cyc(2);
        check("timeout_start_ignored", 128'(pulses - p0), 0);
        bus_rd(1, r); check("timeout_stays_err", r, st(1'b0, 1'b0, 1'b1, 3'd0));
        bus_wr(0, 64'h20);
        err_m = 1'b0;
        run_op(3'd0, 1);

        // Zeroize during BUSY
        bus_wr(0, 64'h5);
        ksel_m = 3'd1;
        cyc(3);
        bus_wr(0, 64'h2);
        for (int s = 0; s < NK; s++) keys_m[s] = '0;
        err_m = 1'b1; ct_m = '0;
        bus_rd(1, r); check("zeroize_status", r[2:0], 3'b100);
        check("zeroize_core_key", core_key, 0);
        check_ct("zeroize_ct");
        core_valid = 1'b1; core_ct = {4{32'hA5A5A5A5}};
        cyc(1);
        core_valid = 1'b0;
        bus_rd(1, r); check("late_valid_status", r[2:0], 3'b100);
        bus_rd(10, r); check("late_valid_ct", r, 0);
        bus_wr(0, 64'h20);
        err_m = 1'b0; ksel_m = 3'd0;
        run_op(3'd1, 2);
        run_op(3'd0, 2);

        // key_sel beyond NUM_KEYS
        bad_start(3'd3);
        bad_start(3'd2);

        // Reset during BUSY
        key_wr(0, 0, $urandom);
        bus_wr(0, 64'h1);
        cyc(2);
        p0 = pulses;
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        for (int s = 0; s < NK; s++) keys_m[s] = '0;
        pt_m = '0; iv_m = '0; ct_m = '0; err_m = 1'b0; ksel_m = '0;
        check("rst_busy_start", core_start, 0);
        check("rst_busy_key", core_key, 0);
        check("rst_busy_pt", core_pt, 0);
        core_valid = 1'b1; core_ct = {4{32'h5A5A5A5A}};
        cyc(1);
        core_valid = 1'b0;
        cyc(2);
        check("rst_busy_no_pulse", 128'(pulses - p0), 0);
        bus_rd(1, r); check("rst_busy_status", r, 0);
        bus_rd(10, r); check("rst_busy_ct", r, 0);
        run_op(3'd0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
